// File: rtl/whack_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// whack_pkg : shared hole geometry, colours and pipeline types   (rev 1.0)
// ---------------------------------------------------------------------------
package whack_pkg;

   localparam int HOLE_COUNT  = 9;
   localparam int SPRITE_SIZE = 16;

   // Index 0 is the leftmost column / top row.
   localparam logic [2:0][9:0] HOLE_X = {10'd448, 10'd288, 10'd128};
   localparam logic [2:0][9:0] HOLE_Y = {10'd368, 10'd240, 10'd112};

   localparam logic [11:0] COLOR_BLACK  = 12'h000;
   localparam logic [11:0] COLOR_GRASS  = 12'h0A0;
   localparam logic [11:0] COLOR_HOLE   = 12'h420;
   localparam logic [11:0] COLOR_CURSOR = 12'hFF0;

   localparam logic [1:0] SHAPE_MOLE = 2'd0;
   localparam logic [3:0] NO_CURSOR  = 4'd15;

   typedef struct packed {
      logic       hole;
      logic [3:0] idx;
      logic       on_edge;
      logic       video_on;
      logic       hsync;
      logic       vsync;
   } stage_t;

   localparam stage_t STAGE_RESET = '{hole: 1'b0, idx: 4'd0, on_edge: 1'b0,
                                      video_on: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage
`default_nettype wire

// File: rtl/hole_locator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hole_locator : maps a screen pixel to hole index and sprite coords (rev 1.0)
// ---------------------------------------------------------------------------
module hole_locator
   import whack_pkg::*;
#(
   parameter int SCALE = 4
) (
   input  logic [9:0] hcount,
   input  logic [9:0] vcount,
   output logic       hole,
   output logic [3:0] hole_idx,
   output logic [3:0] sx,
   output logic [3:0] sy,
   output logic       on_edge
);

   localparam logic [9:0] AREA = 10'(SPRITE_SIZE * SCALE);

   logic       in_col, in_row;
   logic [1:0] col, row;
   logic [9:0] lx, ly;

   always_comb begin
      in_col = 1'b0;
      in_row = 1'b0;
      col    = 2'd0;
      row    = 2'd0;
      lx     = 10'd0;
      ly     = 10'd0;
      for (int i = 0; i < 3; i++) begin
         if (hcount >= HOLE_X[i] && hcount < HOLE_X[i] + AREA) begin
            in_col = 1'b1;
            col    = 2'(i);
            lx     = hcount - HOLE_X[i];
         end
         if (vcount >= HOLE_Y[i] && vcount < HOLE_Y[i] + AREA) begin
            in_row = 1'b1;
            row    = 2'(i);
            ly     = vcount - HOLE_Y[i];
         end
      end
      hole     = in_col && in_row;
      hole_idx = {2'b00, row} * 4'd3 + {2'b00, col};
      // Constant divisor: reduces to a shift for power-of-two SCALE.
      sx       = 4'(lx / SCALE);
      sy       = 4'(ly / SCALE);
      on_edge  = (lx < 10'd2) || (lx >= AREA - 10'd2) ||
                 (ly < 10'd2) || (ly >= AREA - 10'd2);
   end

endmodule
`default_nettype wire

// File: rtl/sprite_compositor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sprite_compositor : 3-stage mole/hole/cursor compositor over VGA    (rev 1.0)
// ---------------------------------------------------------------------------
module sprite_compositor
   import whack_pkg::*;
#(
   parameter int          SCALE        = 4,
   parameter logic [11:0] BG_COLOR     = COLOR_GRASS,
   parameter logic [11:0] HOLE_COLOR   = COLOR_HOLE,
   parameter logic [11:0] CURSOR_COLOR = COLOR_CURSOR
) (
   input  logic                  clk,
   input  logic                  Reset,
   input  logic                  pix_en,
   input  logic [9:0]            hcount,
   input  logic [9:0]            vcount,
   input  logic                  video_on_in,
   input  logic                  hsync_in,
   input  logic                  vsync_in,
   input  logic [HOLE_COUNT-1:0] mole_active,
   input  logic [3:0]            cursor_hole,
   output logic [3:0]            sprite_x,
   output logic [3:0]            sprite_y,
   output logic [1:0]            sprite_shape,
   input  logic                  sprite_r,
   input  logic                  sprite_g,
   input  logic                  sprite_b,
   input  logic                  sprite_a,
   output logic [11:0]           vga_rgb,
   output logic                  vga_hsync,
   output logic                  vga_vsync
);

   logic                  loc_hole, loc_edge;
   logic [3:0]            loc_idx, loc_x, loc_y;
   stage_t                s1, s2;
   logic [HOLE_COUNT-1:0] shadow_mask;
   logic [3:0]            shadow_cursor;
   logic [11:0]           color;

   hole_locator #(.SCALE(SCALE)) u_locator (
      .hcount   (hcount),
      .vcount   (vcount),
      .hole     (loc_hole),
      .hole_idx (loc_idx),
      .sx       (loc_x),
      .sy       (loc_y),
      .on_edge  (loc_edge)
   );

   assign sprite_shape = SHAPE_MOLE;

   always_ff @(posedge clk) begin
      if (Reset) begin
         s1            <= STAGE_RESET;
         s2            <= STAGE_RESET;
         sprite_x      <= 4'd0;
         sprite_y      <= 4'd0;
         vga_rgb       <= COLOR_BLACK;
         vga_hsync     <= 1'b1;
         vga_vsync     <= 1'b1;
         shadow_mask   <= '0;
         shadow_cursor <= NO_CURSOR;
      end else if (pix_en) begin
         s1 <= '{hole: loc_hole, idx: loc_idx, on_edge: loc_edge,
                 video_on: video_on_in, hsync: hsync_in, vsync: vsync_in};
         if (loc_hole) begin
            sprite_x <= loc_x;
            sprite_y <= loc_y;
         end
         // s2 lines up with the sprite memory word addressed from s1.
         s2        <= s1;
         vga_rgb   <= color;
         vga_hsync <= s2.hsync;
         vga_vsync <= s2.vsync;
         if (hcount == 10'd0 && vcount == 10'd0) begin
            shadow_mask   <= mole_active;
            shadow_cursor <= cursor_hole;
         end
      end
   end

   // Hole indices never exceed 8, so cursor values 9..15 never match.
   always_comb begin
      color = BG_COLOR;
      if (!s2.video_on)
         color = COLOR_BLACK;
      else if (s2.hole && s2.idx == shadow_cursor && s2.on_edge)
         color = CURSOR_COLOR;
      else if (s2.hole && shadow_mask[s2.idx] && sprite_a)
         color = {{4{sprite_r}}, {4{sprite_g}}, {4{sprite_b}}};
      else if (s2.hole)
         color = HOLE_COLOR;
   end

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sprite_compositor : scoreboard bench with a behavioural sprite ROM
// ---------------------------------------------------------------------------
module tb_sprite_compositor;

   localparam int SC = 4;

   logic       clk = 1'b0;
   logic       Reset = 1'b0;
   logic       pix_en = 1'b0;
   logic [9:0] hcount = '0, vcount = '0;
   logic       video_on_in = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
   logic [8:0] mole_active = '0;
   logic [3:0] cursor_hole = 4'd15;
   logic [3:0] sprite_x, sprite_y;
   logic [1:0] sprite_shape;
   logic       sprite_r = 1'b0, sprite_g = 1'b0, sprite_b = 1'b0, sprite_a = 1'b0;
   logic [11:0] vga_rgb;
   logic       vga_hsync, vga_vsync;

   always #5 clk = ~clk;

   sprite_compositor dut (
      .clk(clk), .Reset(Reset), .pix_en(pix_en),
      .hcount(hcount), .vcount(vcount),
      .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .mole_active(mole_active), .cursor_hole(cursor_hole),
      .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_shape(sprite_shape),
      .sprite_r(sprite_r), .sprite_g(sprite_g), .sprite_b(sprite_b), .sprite_a(sprite_a),
      .vga_rgb(vga_rgb), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
   );

   // Sprite ROM content: {r,g,b,a}; (0,1) -> r1 g0 b1 a1, (3,3) -> transparent.
   function automatic logic [3:0] spr(input logic [3:0] x, input logic [3:0] y);
      logic [3:0] d;
      d = x ^ y;
      return {x[0] ^ y[0], x[1], ~y[1], |d[1:0]};
   endfunction

   always @(posedge clk)
      if (pix_en) {sprite_r, sprite_g, sprite_b, sprite_a} <= spr(sprite_x, sprite_y);

   typedef struct {
      bit         hole;
      int         idx;
      bit         edg;
      logic [3:0] x, y;
      bit         von, hs, vs;
   } exp_t;

   exp_t       q[$];
   logic [3:0] m_x, m_y;
   logic [8:0] m_mask;
   logic [3:0] m_cur;
   logic [11:0] last_rgb;
   bit         last_hs, last_vs;
   int         n_checks = 0;
   int         n_fail = 0;
   int         rows[16] = '{112, 113, 116, 130, 174, 175, 176, 240,
                            241, 252, 302, 303, 304, 368, 431, 432};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic locate(input int h, input int v, output exp_t e);
      int lx, ly, col, row;
      col = -1; row = -1; lx = 0; ly = 0;
      for (int c = 0; c < 3; c++) begin
         if (h >= 128 + 160 * c && h < 128 + 160 * c + 16 * SC) begin col = c; lx = h - (128 + 160 * c); end
         if (v >= 112 + 128 * c && v < 112 + 128 * c + 16 * SC) begin row = c; ly = v - (112 + 128 * c); end
      end
      e.hole = (col >= 0) && (row >= 0);
      e.idx  = row * 3 + col;
      e.x    = 4'(lx / SC);
      e.y    = 4'(ly / SC);
      e.edg  = lx < 2 || lx >= 16 * SC - 2 || ly < 2 || ly >= 16 * SC - 2;
   endtask

   function automatic logic [11:0] exp_color(input exp_t e, input logic [8:0] mask, input logic [3:0] cur);
      logic [3:0] p;
      p = spr(e.x, e.y);
      if (!e.von) return 12'h000;
      if (e.hole && int'(cur) == e.idx && e.edg) return 12'hFF0;
      if (e.hole && mask[e.idx] && p[0]) return {{4{p[3]}}, {4{p[2]}}, {4{p[1]}}};
      if (e.hole) return 12'h420;
      return 12'h0A0;
   endfunction

   // One pix_en tick followed by gap idle clocks that must hold every output.
   task automatic tick(input int h, input int v, input bit von, input bit hs, input bit vs, input int gap);
      exp_t e, o;
      logic [8:0] mask_b;
      logic [3:0] cur_b;
      mask_b = m_mask;
      cur_b  = m_cur;
      hcount = 10'(h); vcount = 10'(v);
      video_on_in = von; hsync_in = hs; vsync_in = vs;
      locate(h, v, e);
      if (e.hole) begin m_x = e.x; m_y = e.y; end
      e.x = m_x; e.y = m_y;
      e.von = von; e.hs = hs; e.vs = vs;
      if (h == 0 && v == 0) begin m_mask = mole_active; m_cur = cursor_hole; end
      q.push_back(e);
      pix_en = 1'b1;
      @(posedge clk); #1;
      pix_en = 1'b0;
      check("sprite_x", 32'(sprite_x), 32'(m_x));
      check("sprite_y", 32'(sprite_y), 32'(m_y));
      check("sprite_shape", 32'(sprite_shape), 32'd0);
      o = q.pop_front();
      last_rgb = exp_color(o, mask_b, cur_b);
      last_hs  = o.hs;
      last_vs  = o.vs;
      check("vga_rgb", 32'(vga_rgb), 32'(last_rgb));
      check("vga_hsync", 32'(vga_hsync), 32'(last_hs));
      check("vga_vsync", 32'(vga_vsync), 32'(last_vs));
      for (int g = 0; g < gap; g++) begin
         @(posedge clk); #1;
         check("hold_rgb", 32'(vga_rgb), 32'(last_rgb));
         check("hold_hsync", 32'(vga_hsync), 32'(last_hs));
         check("hold_sprite_x", 32'(sprite_x), 32'(m_x));
      end
   endtask

   task automatic do_reset();
      exp_t r;
      Reset = 1'b1; pix_en = 1'b1;
      hcount = '0; vcount = '0; video_on_in = 1'b1; mole_active = 9'h1FF;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rgb", 32'(vga_rgb), 32'h000);
      check("rst_hsync", 32'(vga_hsync), 32'd1);
      check("rst_vsync", 32'(vga_vsync), 32'd1);
      check("rst_sprite_x", 32'(sprite_x), 32'd0);
      check("rst_sprite_y", 32'(sprite_y), 32'd0);
      Reset = 1'b0; pix_en = 1'b0;
      q.delete();
      r = '{hole: 0, idx: 0, edg: 0, x: 4'd0, y: 4'd0, von: 0, hs: 1, vs: 1};
      q.push_back(r);
      q.push_back(r);
      m_x = 4'd0; m_y = 4'd0; m_mask = 9'h000; m_cur = 4'd15;
   endtask

   task automatic scan(input int v, input int h0, input int h1, input int gap);
      for (int h = h0; h <= h1; h++)
         tick(h, v, 1'b1, (h % 37) != 5, v != 490, gap);
   endtask

   initial begin
      do_reset();
      repeat (3) tick(10, 10, 1'b0, 1'b1, 1'b1, 0);
      check("idle_black", 32'(vga_rgb), 32'h000);

      // Single opaque pixel in hole 0, then sync latency on a grass pixel.
      mole_active = 9'h001; cursor_hole = 4'd15;
      tick(0, 0, 1'b0, 1'b1, 1'b1, 0);
      tick(130, 116, 1'b1, 1'b1, 1'b1, 0);
      check("sx_130", 32'(sprite_x), 32'd0);
      check("sy_116", 32'(sprite_y), 32'd1);
      tick(10, 10, 1'b1, 1'b0, 1'b1, 0);
      tick(10, 10, 1'b1, 1'b1, 1'b1, 0);
      check("mole_pixel", 32'(vga_rgb), 32'hF0F);
      tick(10, 10, 1'b1, 1'b1, 1'b1, 0);
      check("grass_pixel", 32'(vga_rgb), 32'h0A0);
      check("hsync_latency", 32'(vga_hsync), 32'd0);
      tick(10, 10, 1'b1, 1'b1, 1'b1, 0);
      check("hsync_release", 32'(vga_hsync), 32'd1);

      // Mask changes mid-frame stay invisible until the next frame origin.
      mole_active = 9'h000;
      tick(0, 0, 1'b0, 1'b1, 1'b0, 0);
      mole_active = 9'h1FF;
      for (int r = 0; r < 4; r++) scan(rows[r], 120, 520, 0);
      tick(0, 0, 1'b0, 1'b1, 1'b0, 0);
      for (int r = 0; r < 4; r++) scan(rows[r], 120, 520, 0);

      // Cursor on the centre hole.
      cursor_hole = 4'd4;
      tick(0, 0, 1'b0, 1'b1, 1'b0, 0);
      for (int r = 7; r < 13; r++) scan(rows[r], 280, 360, 0);
      tick(288, 240, 1'b1, 1'b1, 1'b1, 0);
      tick(300, 252, 1'b1, 1'b1, 1'b1, 0);
      tick(10, 10, 1'b1, 1'b1, 1'b1, 0);
      check("cursor_corner", 32'(vga_rgb), 32'hFF0);
      tick(10, 10, 1'b1, 1'b1, 1'b1, 0);
      check("hole_transparent", 32'(vga_rgb), 32'h420);

      // Out-of-range cursor draws nothing.
      cursor_hole = 4'd12;
      tick(0, 0, 1'b0, 1'b1, 1'b0, 0);
      for (int r = 0; r < 16; r += 3) scan(rows[r], 120, 520, 0);

      // Sparse strobe across a whole line.
      scan(116, 0, 799, 3);

      // Reset in mid-frame: black pipeline, cleared mask until next origin.
      scan(370, 440, 460, 0);
      do_reset();
      scan(370, 440, 520, 0);
      tick(0, 0, 1'b0, 1'b1, 1'b0, 0);
      scan(370, 440, 520, 0);
      scan(431, 440, 520, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
